// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: Moore outputs registered from the next state,
// with mem_ready gating on fetch strobes and a combinational pcen term.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        ERROR   = 4'd12
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluc;
        logic       pcwrite;
        logic       branch;
        logic       illegal;
        logic       gate;     // fetch strobes wait on mem_ready
    } ctrl_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    // {legal, alucontrol} for an R-type funct field
    function automatic logic [3:0] alu_dec(input logic [5:0] f);
        logic [3:0] r;
        case (f)
            6'b100000: r = 4'b1_010;
            6'b100010: r = 4'b1_110;
            6'b100100: r = 4'b1_000;
            6'b100101: r = 4'b1_001;
            6'b101010: r = 4'b1_111;
            default:   r = 4'b0_010;
        endcase
        return r;
    endfunction

    function automatic state_t next_of(input state_t s, input logic [5:0] o,
                                       input logic [5:0] f, input logic mr);
        state_t     n;
        logic [3:0] a;
        a = alu_dec(f);
        case (s)
            FETCH:   n = mr ? DECODE : FETCH;
            DECODE: begin
                case (o)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_R:         n = EXECUTE;
                    OP_BEQ:       n = BRANCH;
                    OP_ADDI:      n = ADDIEX;
                    OP_J:         n = JUMP;
                    default:      n = ERROR;
                endcase
            end
            MEMADR:  n = (o == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   n = mr ? MEMWB : MEMRD;
            MEMWB:   n = FETCH;
            MEMWR:   n = mr ? FETCH : MEMWR;
            EXECUTE: n = a[3] ? ALUWB : ERROR;
            ALUWB:   n = FETCH;
            BRANCH:  n = FETCH;
            ADDIEX:  n = ADDIWB;
            ADDIWB:  n = FETCH;
            JUMP:    n = FETCH;
            ERROR:   n = ERROR;
            default: n = FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] f);
        ctrl_t      c;
        logic [3:0] a;
        a      = alu_dec(f);
        c      = '0;
        c.aluc = 3'b010;
        case (s)
            FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.gate    = 1'b1;
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluc    = a[2:0];
            end
            ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BRANCH: begin
                c.alusrca = 1'b1;
                c.aluc    = 3'b110;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB:  c.regwrite = 1'b1;
            JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            ERROR:   c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_t cur;
    state_t nxt;
    ctrl_t  ctl;
    logic   pcwrite;

    assign nxt = next_of(cur, op, funct, mem_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= FETCH;
            ctl <= ctrl_of(FETCH, 6'b0);
        end else begin
            cur <= nxt;
            ctl <= ctrl_of(nxt, funct);
        end
    end

    // Write enables are also masked by reset so they drop the instant it asserts
    assign pcwrite    = ctl.pcwrite & (mem_ready | ~ctl.gate);
    assign pcen       = reset & (pcwrite | (ctl.branch & zero));
    assign irwrite    = reset & ctl.irwrite & mem_ready;
    assign memwrite   = reset & ctl.memwrite;
    assign regwrite   = reset & ctl.regwrite;
    assign iord       = ctl.iord;
    assign regdst     = ctl.regdst;
    assign memtoreg   = ctl.memtoreg;
    assign alusrca    = ctl.alusrca;
    assign alusrcb    = ctl.alusrcb;
    assign pcsrc      = ctl.pcsrc;
    assign alucontrol = ctl.aluc;
    assign illegal    = ctl.illegal;
    assign state      = cur;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction expected cycle plans built from the
// instruction rules, replayed against the DUT with random stalls and resets.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluc;
        logic       illegal;
    } exp_t;

    typedef struct {
        logic mr;
        logic z;
        exp_t e;
    } cyc_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    cyc_t        plan[$];
    int          n_cmp = 0, n_bad = 0;
    bit          errored;
    logic [31:0] obs;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] st);
        exp_t e;
        e      = '0;
        e.st   = st;
        e.aluc = 3'b010;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t e;
        e = {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, illegal};
        return e;
    endfunction

    task automatic push(input logic mr, input logic z, input exp_t e);
        cyc_t c;
        c.mr = mr;
        c.z  = z;
        c.e  = e;
        plan.push_back(c);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycles of one instruction: sf fetch stalls, sm memory stalls
    task automatic plan_instr(input logic [5:0] o, input logic [5:0] f,
                              input int sf, input int sm, input logic bz);
        exp_t e;
        errored = 0;
        e = mk(4'd0);
        e.alusrcb = 2'b01;
        for (int i = 0; i < sf; i++) push(1'b0, rb(), e);
        e.irwrite = 1'b1;
        e.pcen    = 1'b1;
        push(1'b1, rb(), e);
        e = mk(4'd1);
        e.alusrcb = 2'b11;
        push(rb(), rb(), e);
        if (o == LW || o == SW) begin
            e = mk(4'd2);
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
            push(rb(), rb(), e);
            e = mk(o == LW ? 4'd3 : 4'd5);
            e.iord = 1'b1;
            e.memwrite = (o == SW);
            for (int i = 0; i < sm; i++) push(1'b0, rb(), e);
            push(1'b1, rb(), e);
            if (o == LW) begin
                e = mk(4'd4);
                e.memtoreg = 1'b1;
                e.regwrite = 1'b1;
                push(rb(), rb(), e);
            end
        end else if (o == RT) begin
            e = mk(4'd6);
            e.alusrca = 1'b1;
            case (f)
                6'b100000: e.aluc = 3'b010;
                6'b100010: e.aluc = 3'b110;
                6'b100100: e.aluc = 3'b000;
                6'b100101: e.aluc = 3'b001;
                6'b101010: e.aluc = 3'b111;
                default:   errored = 1;
            endcase
            push(rb(), rb(), e);
            if (!errored) begin
                e = mk(4'd7);
                e.regdst   = 1'b1;
                e.regwrite = 1'b1;
                push(rb(), rb(), e);
            end
        end else if (o == BEQ) begin
            e = mk(4'd8);
            e.alusrca = 1'b1;
            e.aluc    = 3'b110;
            e.pcsrc   = 2'b01;
            e.pcen    = bz;
            push(rb(), bz, e);
        end else if (o == ADDI) begin
            e = mk(4'd9);
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
            push(rb(), rb(), e);
            e = mk(4'd10);
            e.regwrite = 1'b1;
            push(rb(), rb(), e);
        end else if (o == JMP) begin
            e = mk(4'd11);
            e.pcsrc = 2'b10;
            e.pcen  = 1'b1;
            push(rb(), rb(), e);
        end else begin
            errored = 1;
        end
        if (errored) begin
            e = mk(4'd12);
            e.illegal = 1'b1;
            for (int i = 0; i < 10; i++) push(rb(), rb(), e);
        end
    endtask

    task automatic run_plan(input logic [5:0] o, input logic [5:0] f);
        cyc_t c;
        op    = o;
        funct = f;
        obs   = '0;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(negedge clk);
            mem_ready = c.mr;
            zero      = c.z;
            #1;
            obs = {obs[27:0], state};
            check("cycle", 32'(observed()), 32'(c.e));
        end
    endtask

    // Asynchronous reset mid-cycle, held across one edge, released mid-cycle
    task automatic do_reset();
        @(negedge clk);
        mem_ready = 1'b1;
        zero      = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_async_state", 32'(state), 32'd0);
        check("rst_async_illegal", 32'(illegal), 32'd0);
        check("rst_async_we", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold", 32'({state, pcen, irwrite, memwrite, regwrite}), 32'd0);
        #1 reset = 1'b1;
    endtask

    function automatic logic [5:0] rand_funct();
        logic [5:0] t[5];
        t = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        if ($urandom_range(0, 19) == 0) return 6'($urandom);
        return t[$urandom_range(0, 4)];
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] t[6];
        t = '{LW, SW, RT, BEQ, ADDI, JMP};
        if ($urandom_range(0, 24) == 0) return 6'($urandom);
        return t[$urandom_range(0, 5)];
    endfunction

    initial begin
        int cnt;
        logic [5:0] o, f;
        logic [5:0] rt_f[5];
        logic [2:0] rt_a[5];

        reset = 1'b0;
        mem_ready = 1'b1;
        zero = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_we", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        // lw, no stalls: five cycles through states 0..4
        plan_instr(LW, 6'd0, 0, 0, 1'b0);
        check("lw_len", 32'(plan.size()), 32'd5);
        run_plan(LW, 6'd0);
        check("lw_states", obs, 32'h0001_2340 >> 4);

        // sw held off for three cycles: memwrite over four cycles
        plan_instr(SW, 6'd0, 0, 3, 1'b0);
        cnt = 0;
        foreach (plan[i]) cnt += int'(plan[i].e.memwrite);
        check("sw_memwrite_cycles", 32'(cnt), 32'd4);
        run_plan(SW, 6'd0);

        // beq taken and not taken
        plan_instr(BEQ, 6'd0, 0, 0, 1'b1);
        check("beq_len", 32'(plan.size()), 32'd3);
        run_plan(BEQ, 6'd0);
        plan_instr(BEQ, 6'd0, 0, 0, 1'b0);
        check("beq_nt_pcen", 32'(plan[2].e.pcen), 32'd0);
        run_plan(BEQ, 6'd0);

        // R-type funct walk
        rt_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        rt_a = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 5; i++) begin
            plan_instr(RT, rt_f[i], 0, 0, 1'b0);
            check("rtype_aluc_model", 32'(plan[2].e.aluc), 32'(rt_a[i]));
            run_plan(RT, rt_f[i]);
        end

        // addi after five fetch stalls, then j
        plan_instr(ADDI, 6'd0, 5, 0, 1'b0);
        check("addi_len", 32'(plan.size()), 32'd9);
        run_plan(ADDI, 6'd0);
        plan_instr(JMP, 6'd0, 0, 0, 1'b0);
        check("j_len", 32'(plan.size()), 32'd3);
        run_plan(JMP, 6'd0);

        // illegal opcode: decode, then ERROR held until reset
        plan_instr(6'b111111, 6'd0, 0, 0, 1'b0);
        run_plan(6'b111111, 6'd0);
        check("illegal_held", 32'({state, illegal}), 32'({4'd12, 1'b1}));
        do_reset();

        // randomized instruction stream with occasional mid-instruction resets
        for (int n = 0; n < 300; n++) begin
            int sf, sm, keep;
            o  = rand_op();
            f  = rand_funct();
            sf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            sm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
            plan_instr(o, f, sf, sm, rb());
            if ($urandom_range(0, 15) == 0) begin
                keep = $urandom_range(1, plan.size());
                while (plan.size() > keep) void'(plan.pop_back());
                errored = 1;
            end
            run_plan(o, f);
            if (errored) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
